mem_arbiter: RTL and testbench

Round-robin arbiter that shares one BRAM memory port (independent write and read channels, fixed read latency) between NREQ requesters. Sits between the requester-side memory masters and the BRAM slave. Grants each channel independently every cycle. Routes each read return back to the requester that issued the read, using an in-flight tag pipeline.

---
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one BRAM port (separate write and read channels, fixed read latency)
// between NREQ requesters. Each channel is arbitrated on its own every cycle.
// Read returns are steered back to the issuing requester by a tag pipeline
// that is as deep as the BRAM read latency.
//
// Build option:
//   MEM_ARB_RR_EN defined   -> round-robin arbitration per channel.
//   MEM_ARB_RR_EN undefined -> fixed priority, lowest index wins (no pointers).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_wen/s_waddr/s_wdata    per-requester write request, address, data (packed)
//   s_wgnt                   one-hot write grant (combinational)
//   s_ren/s_raddr            per-requester read request and address (packed)
//   s_rgnt                   one-hot read grant (combinational)
//   s_rdata                  read data, broadcast to all requesters
//   s_rvalid                 one-hot read-return strobe
//   m_wen/m_waddr/m_wdata    BRAM write channel
//   m_ren/m_raddr            BRAM read channel
//   m_rdata/m_rvalid         BRAM read return
module mem_arbiter #(
  parameter int ALEN   = 1,
  parameter int DLEN   = 8,
  parameter int NREQ   = 2,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      s_wen,
  input  logic [NREQ*ALEN-1:0] s_waddr,
  input  logic [NREQ*DLEN-1:0] s_wdata,
  output logic [NREQ-1:0]      s_wgnt,
  input  logic [NREQ-1:0]      s_ren,
  input  logic [NREQ*ALEN-1:0] s_raddr,
  output logic [NREQ-1:0]      s_rgnt,
  output logic [DLEN-1:0]      s_rdata,
  output logic [NREQ-1:0]      s_rvalid,
  output logic                 m_wen,
  output logic [ALEN-1:0]      m_waddr,
  output logic [DLEN-1:0]      m_wdata,
  output logic                 m_ren,
  output logic [ALEN-1:0]      m_raddr,
  input  logic [DLEN-1:0]      m_rdata,
  input  logic                 m_rvalid
);

  // NREQ is limited to 2..4, so one or two bits hold any requester index.
  localparam int IW = (NREQ > 2) ? 2 : 1;

  // First requesting index scanning ptr, ptr+1, ... modulo NREQ.
  function automatic logic [NREQ-1:0] pick(input logic [NREQ-1:0] req,
                                           input logic [IW-1:0]   ptr);
    logic [NREQ-1:0] g;
    logic            found;
    int              k;
    g     = '0;
    found = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      k = (int'(ptr) + j) % NREQ;
      if (!found && req[k]) begin
        g[k]  = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [IW-1:0] oh2idx(input logic [NREQ-1:0] oh);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  logic [IW-1:0] wptr;
  logic [IW-1:0] rptr;
  logic [IW-1:0] ridx;

`ifdef MEM_ARB_RR_EN
  logic [IW-1:0] widx;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
    if (int'(i) == NREQ - 1) return '0;
    else                     return i + 1'b1;
  endfunction

  assign widx = oh2idx(s_wgnt);

  // m_wen/m_ren are already forced low in reset, so no grant can move a
  // pointer while rst is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (m_wen) wptr <= next_ptr(widx);
      if (m_ren) rptr <= next_ptr(ridx);
    end
  end
`else
  // Fixed priority is round-robin with the pointer pinned at index 0.
  assign wptr = '0;
  assign rptr = '0;
`endif

  assign s_wgnt = rst ? '0 : pick(s_wen, wptr);
  assign s_rgnt = rst ? '0 : pick(s_ren, rptr);
  assign m_wen  = |s_wgnt;
  assign m_ren  = |s_rgnt;
  assign ridx   = oh2idx(s_rgnt);

  always_comb begin
    m_waddr = '0;
    m_wdata = '0;
    m_raddr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (s_wgnt[i]) begin
        m_waddr = s_waddr[i*ALEN +: ALEN];
        m_wdata = s_wdata[i*DLEN +: DLEN];
      end
      if (s_rgnt[i]) m_raddr = s_raddr[i*ALEN +: ALEN];
    end
  end

  // Tag pipeline: stage 0 takes the read issued this cycle, the last stage
  // lines up with the BRAM's m_rvalid for that read.
  logic [RD_LAT-1:0]         tag_v;
  logic [RD_LAT-1:0][IW-1:0] tag_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= m_ren;
      tag_id[0] <= ridx;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  // A BRAM return with no matching tag is dropped; a tag with no BRAM
  // return produces no strobe.
  always_comb begin
    s_rvalid = '0;
    if (!rst && m_rvalid && tag_v[RD_LAT-1]) begin
      for (int i = 0; i < NREQ; i++) begin
        if (int'(tag_id[RD_LAT-1]) == i) s_rvalid[i] = 1'b1;
      end
    end
  end

  assign s_rdata = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Scoreboard bench for mem_arbiter (NREQ=2, ALEN=1, DLEN=8, RD_LAT=2).
// Stimulus pushes expected write issues, read issues and read returns (each
// stamped with the cycle it must appear in); a negedge monitor pops and
// compares whenever the DUT drives m_wen, m_ren or s_rvalid. A small BRAM
// model with 2-cycle read latency sits on the master side.
// Expected grant order follows MEM_ARB_RR_EN the same way the DUT build does.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] s_wen;
  logic [1:0] s_waddr;
  logic [15:0] s_wdata;
  logic [1:0] s_wgnt;
  logic [1:0] s_ren;
  logic [1:0] s_raddr;
  logic [1:0] s_rgnt;
  logic [7:0] s_rdata;
  logic [1:0] s_rvalid;
  logic       m_wen;
  logic       m_waddr;
  logic [7:0] m_wdata;
  logic       m_ren;
  logic       m_raddr;
  logic [7:0] m_rdata;
  logic       m_rvalid;

  mem_arbiter #(.ALEN(1), .DLEN(8), .NREQ(2), .RD_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .s_wen(s_wen), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wgnt(s_wgnt),
    .s_ren(s_ren), .s_raddr(s_raddr), .s_rgnt(s_rgnt),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .m_wen(m_wen), .m_waddr(m_waddr), .m_wdata(m_wdata),
    .m_ren(m_ren), .m_raddr(m_raddr),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model, 2-cycle read latency.
  logic [7:0] mem [0:1] = '{8'h00, 8'hA5};
  logic [7:0] rd_d0 = '0, rd_d1 = '0;
  logic       rd_v0 = 1'b0, rd_v1 = 1'b0;
  always @(posedge clk) begin
    if (m_wen) mem[m_waddr] <= m_wdata;
    rd_v0 <= m_ren;
    rd_d0 <= mem[m_raddr];
    rd_v1 <= rd_v0;
    rd_d1 <= rd_d0;
  end
  assign m_rvalid = rd_v1;
  assign m_rdata  = rd_d1;

  typedef struct packed {
    int         cyc;
    logic [1:0] oh;
    logic       addr;
    logic [7:0] data;
  } exp_t;

  exp_t wq[$];
  exp_t rq[$];
  exp_t vq[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic exp_w(input logic [1:0] oh, input logic a, input logic [7:0] d);
    exp_t e;
    e.cyc = cyc; e.oh = oh; e.addr = a; e.data = d;
    wq.push_back(e);
  endtask

  task automatic exp_r(input logic [1:0] oh, input logic a);
    exp_t e;
    e.cyc = cyc; e.oh = oh; e.addr = a; e.data = 8'h00;
    rq.push_back(e);
  endtask

  task automatic exp_v(input int c, input logic [1:0] oh, input logic [7:0] d);
    exp_t e;
    e.cyc = c; e.oh = oh; e.addr = 1'b0; e.data = d;
    vq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    n_cmp++;
    if (m_wen) begin
      if (wq.size() == 0) begin
        n_bad++;
        $display("FAIL wr_unexpected cyc=%0d got gnt=%b addr=%h data=%h", cyc, s_wgnt, m_waddr, m_wdata);
      end else begin
        e = wq.pop_front();
        if (cyc != e.cyc || s_wgnt != e.oh || m_waddr != e.addr || m_wdata != e.data) begin
          n_bad++;
          $display("FAIL wr_issue got cyc=%0d gnt=%b addr=%h data=%h exp cyc=%0d gnt=%b addr=%h data=%h",
                   cyc, s_wgnt, m_waddr, m_wdata, e.cyc, e.oh, e.addr, e.data);
        end
      end
    end else if (s_wgnt != 2'b00 || m_waddr != 1'b0 || m_wdata != 8'h00) begin
      n_bad++;
      $display("FAIL wr_idle cyc=%0d got gnt=%b addr=%h data=%h exp all 0", cyc, s_wgnt, m_waddr, m_wdata);
    end

    n_cmp++;
    if (m_ren) begin
      if (rq.size() == 0) begin
        n_bad++;
        $display("FAIL rd_unexpected cyc=%0d got gnt=%b addr=%h", cyc, s_rgnt, m_raddr);
      end else begin
        e = rq.pop_front();
        if (cyc != e.cyc || s_rgnt != e.oh || m_raddr != e.addr) begin
          n_bad++;
          $display("FAIL rd_issue got cyc=%0d gnt=%b addr=%h exp cyc=%0d gnt=%b addr=%h",
                   cyc, s_rgnt, m_raddr, e.cyc, e.oh, e.addr);
        end
      end
    end else if (s_rgnt != 2'b00 || m_raddr != 1'b0) begin
      n_bad++;
      $display("FAIL rd_idle cyc=%0d got gnt=%b addr=%h exp 0", cyc, s_rgnt, m_raddr);
    end

    if (s_rvalid != 2'b00) begin
      n_cmp++;
      if (vq.size() == 0) begin
        n_bad++;
        $display("FAIL ret_unexpected cyc=%0d got rvalid=%b rdata=%h", cyc, s_rvalid, s_rdata);
      end else begin
        e = vq.pop_front();
        if (cyc != e.cyc || s_rvalid != e.oh || s_rdata != e.data) begin
          n_bad++;
          $display("FAIL ret got cyc=%0d rvalid=%b rdata=%h exp cyc=%0d rvalid=%b rdata=%h",
                   cyc, s_rvalid, s_rdata, e.cyc, e.oh, e.data);
        end
      end
    end
  end

  task automatic check_reset_quiet();
    @(negedge clk);
    n_cmp++;
    if ({s_wgnt, s_rgnt, m_wen, m_ren, s_rvalid} != 8'h00) begin
      n_bad++;
      $display("FAIL reset_quiet cyc=%0d got wgnt=%b rgnt=%b mwen=%b mren=%b rvalid=%b exp all 0",
               cyc, s_wgnt, s_rgnt, m_wen, m_ren, s_rvalid);
    end
  endtask

  task automatic check_empty(input string name, input int sz);
    n_cmp++;
    if (sz != 0) begin
      n_bad++;
      $display("FAIL %s got %0d pending exp 0", name, sz);
    end
  endtask

  logic [1:0] oh;

  initial begin
    rst     = 1'b1;
    s_wen   = 2'b11;
    s_ren   = 2'b11;
    s_waddr = 2'b10;
    s_raddr = 2'b10;
    s_wdata = {8'hA5, 8'h3C};

    // Reset held with every request up.
    repeat (3) begin
      step();
      check_reset_quiet();
    end

    // Both requesters write for 4 cycles.
    step();
    rst   = 1'b0;
    s_ren = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
`ifdef MEM_ARB_RR_EN
      oh = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
      oh = 2'b01;
`endif
      exp_w(oh, oh[1], oh[1] ? 8'hA5 : 8'h3C);
    end

    // Single read from requester 1.
    step();
    s_wen = 2'b00;
    s_ren = 2'b10;
    exp_r(2'b10, 1'b1);
    exp_v(cyc + 2, 2'b10, 8'hA5);

    // Interleaved reads: req0 then req1.
    step();
    s_ren = 2'b01;
    exp_r(2'b01, 1'b0);
    exp_v(cyc + 2, 2'b01, 8'h3C);
    step();
    s_ren = 2'b10;
    exp_r(2'b10, 1'b1);
    exp_v(cyc + 2, 2'b10, 8'hA5);

    // Write and read in the same cycle from different requesters.
    step();
    s_wen = 2'b01;
    s_ren = 2'b10;
    exp_w(2'b01, 1'b0, 8'h3C);
    exp_r(2'b10, 1'b1);
    exp_v(cyc + 2, 2'b10, 8'hA5);

    // Both hold reads for 3 cycles, then req0 drops.
    step();
    s_wen = 2'b00;
    s_ren = 2'b11;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
`ifdef MEM_ARB_RR_EN
      oh = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
      oh = 2'b01;
`endif
      exp_r(oh, oh[1]);
      exp_v(cyc + 2, oh, oh[1] ? 8'hA5 : 8'h3C);
    end
    step();
    s_ren = 2'b10;
    exp_r(2'b10, 1'b1);
    exp_v(cyc + 2, 2'b10, 8'hA5);

    step();
    s_ren = 2'b00;
    step();

    // Reads cut off by reset: the first would return inside the reset
    // cycle, the second just after it. Neither may produce a strobe.
    step();
    s_ren = 2'b10;
    exp_r(2'b10, 1'b1);
    step();
    s_ren = 2'b01;
    exp_r(2'b01, 1'b0);
    step();
    rst   = 1'b1;
    s_wen = 2'b11;
    s_ren = 2'b11;

    // First cycle after reset: both pointers back at index 0.
    step();
    rst = 1'b0;
    exp_w(2'b01, 1'b0, 8'h3C);
    exp_r(2'b01, 1'b0);
    exp_v(cyc + 2, 2'b01, 8'h3C);

    step();
    s_wen = 2'b00;
    s_ren = 2'b00;
    repeat (5) step();
    @(negedge clk);
    #1;
    check_empty("wr_pending", wq.size());
    check_empty("rd_pending", rq.size());
    check_empty("ret_pending", vq.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
